// File: rtl/pipelined_shifter.sv
// Two-stage pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready flow control.
// Low shift-amount bits are applied in stage 1, high bits in stage 2.
module pipelined_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int SPLIT   = SHAMT_W / 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    localparam int HI_W = SHAMT_W - SPLIT;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    logic              r_s1_valid;
    logic [WIDTH-1:0]  r_s1_data;
    logic [HI_W-1:0]   r_s1_shamt_hi;
    op_e               r_s1_op;
    logic              r_s2_valid;
    logic [WIDTH-1:0]  r_s2_data;

    logic              w_s1_advance;
    logic              w_s2_advance;
    logic [WIDTH-1:0]  w_s1_shifted;
    logic [WIDTH-1:0]  w_s2_shifted;

    // SRA fill uses the current MSB, which every earlier arithmetic sub-stage has preserved
    // from the original operand's sign bit.
    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] d, input op_e op, input int amt);
        logic [WIDTH-1:0] sign_fill;
        sign_fill = ~({WIDTH{1'b1}} >> amt);
        case (op)
            OP_SLL:  f_shift = d << amt;
            OP_SRL:  f_shift = d >> amt;
            OP_SRA:  f_shift = (d >> amt) | (d[WIDTH-1] ? sign_fill : '0);
            default: f_shift = (d << amt) | (d >> (WIDTH - amt));
        endcase
    endfunction

    // NOTE: always_comb assigns every output a default first so no latch can be inferred.
    always_comb begin
        w_s1_shifted = in_data;
        for (int k = 0; k < SPLIT; k++) begin
            if (in_shamt[k]) w_s1_shifted = f_shift(w_s1_shifted, op_e'(in_op), 1 << k);
        end
    end

    always_comb begin
        w_s2_shifted = r_s1_data;
        for (int k = 0; k < HI_W; k++) begin
            if (r_s1_shamt_hi[k]) w_s2_shifted = f_shift(w_s2_shifted, r_s1_op, 1 << (k + SPLIT));
        end
    end

    assign w_s2_advance = !r_s2_valid || out_ready;
    assign w_s1_advance = !r_s1_valid || w_s2_advance;
    assign in_ready     = w_s1_advance;
    assign out_valid    = r_s2_valid;
    assign out_data     = r_s2_data;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid    <= 1'b0;
            r_s1_data     <= '0;
            r_s1_shamt_hi <= '0;
            r_s1_op       <= OP_SLL;
            r_s2_valid    <= 1'b0;
            r_s2_data     <= '0;
        end else begin
            if (w_s1_advance) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data     <= w_s1_shifted;
                    r_s1_shamt_hi <= in_shamt[SHAMT_W-1:SPLIT];
                    r_s1_op       <= op_e'(in_op);
                end
            end
            if (w_s2_advance) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) r_s2_data <= w_s2_shifted;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter at WIDTH=32: vector table, streaming, reset and back-pressure.
module tb_pipelined_shifter;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int NVEC    = 17;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [WIDTH-1:0]   d;
        logic [SHAMT_W-1:0] s;
        logic [1:0]         op;
        logic [WIDTH-1:0]   exp;
    } vec_t;

    vec_t vecs[NVEC];

    pipelined_shifter #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s, input logic [1:0] op);
        in_valid = v;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Back-pressure scenario data
    logic [WIDTH-1:0] bp_in[5];
    logic [WIDTH-1:0] bp_exp[5];
    int               bp_p;
    int               bp_q;
    logic             in_fire;
    logic             out_fire;

    initial begin
        vecs[0]  = '{32'h8000_00F1, 5'd4,  2'b00, 32'h0000_0F10};
        vecs[1]  = '{32'h8000_00F1, 5'd4,  2'b01, 32'h0800_000F};
        vecs[2]  = '{32'h8000_00F1, 5'd4,  2'b10, 32'hF800_000F};
        vecs[3]  = '{32'h8000_00F1, 5'd4,  2'b11, 32'h0000_0F18};
        vecs[4]  = '{32'h8000_0001, 5'd0,  2'b00, 32'h8000_0001};
        vecs[5]  = '{32'h8000_0001, 5'd0,  2'b01, 32'h8000_0001};
        vecs[6]  = '{32'h8000_0001, 5'd0,  2'b10, 32'h8000_0001};
        vecs[7]  = '{32'h8000_0001, 5'd0,  2'b11, 32'h8000_0001};
        vecs[8]  = '{32'h8000_0001, 5'd31, 2'b00, 32'h8000_0000};
        vecs[9]  = '{32'h8000_0001, 5'd31, 2'b01, 32'h0000_0001};
        vecs[10] = '{32'h8000_0001, 5'd31, 2'b10, 32'hFFFF_FFFF};
        vecs[11] = '{32'h8000_0001, 5'd31, 2'b11, 32'hC000_0000};
        vecs[12] = '{32'h7000_0000, 5'd4,  2'b10, 32'h0700_0000};
        vecs[13] = '{32'h1234_5678, 5'd8,  2'b11, 32'h3456_7812};
        vecs[14] = '{32'hFFFF_FFFF, 5'd16, 2'b01, 32'h0000_FFFF};
        vecs[15] = '{32'h0000_0001, 5'd17, 2'b00, 32'h0002_0000};
        vecs[16] = '{32'h8765_4321, 5'd13, 2'b10, 32'hFFFC_3B2A};

        bp_in  = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        bp_exp = '{32'h22, 32'h44, 32'h66, 32'h88, 32'hAA};

        // Reset held two cycles
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 2'b00);
        step();
        step();
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);

        // One operand at a time: latency and value
        for (int i = 0; i < NVEC; i++) begin
            drive(1'b1, vecs[i].d, vecs[i].s, vecs[i].op);
            check($sformatf("vec%0d_ready", i), 64'(in_ready), 64'd1);
            step();
            drive(1'b0, '0, '0, 2'b00);
            check($sformatf("vec%0d_early", i), 64'(out_valid), 64'd0);
            step();
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_data", i),  64'(out_data),  64'(vecs[i].exp));
        end

        // Back-to-back stream: one result per cycle
        for (int i = 0; i <= NVEC; i++) begin
            if (i < NVEC) drive(1'b1, vecs[i].d, vecs[i].s, vecs[i].op);
            else          drive(1'b0, '0, '0, 2'b00);
            step();
            if (i >= 1) begin
                check($sformatf("stream%0d_valid", i - 1), 64'(out_valid), 64'd1);
                check($sformatf("stream%0d_data", i - 1),  64'(out_data),  64'(vecs[i-1].exp));
            end
        end
        step();
        check("stream_tail_empty", 64'(out_valid), 64'd0);

        // Reset with a full, stalled pipeline discards everything
        out_ready = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 5'd3, 2'b00);
        step();
        drive(1'b1, 32'hCAFE_F00D, 5'd5, 2'b11);
        step();
        drive(1'b0, '0, '0, 2'b00);
        check("full_in_ready", 64'(in_ready),  64'd0);
        check("full_valid",    64'(out_valid), 64'd1);
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data",  64'(out_data),  64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        step();
        check("midrst_no_ghost",  64'(out_valid), 64'd0);

        // Back-pressure: out_ready low for cycles 3..8 while 5 operands stream in
        bp_p = 0;
        bp_q = 0;
        for (int c = 0; c < 40 && bp_q < 5; c++) begin
            if (bp_p < 5) drive(1'b1, bp_in[bp_p], 5'd1, 2'b00);
            else          drive(1'b0, '0, '0, 2'b00);
            out_ready = !(c >= 3 && c <= 8);
            #1;
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (c >= 4 && c <= 8) begin
                check($sformatf("bp_stall_ready_c%0d", c), 64'(in_ready),  64'd0);
                check($sformatf("bp_stall_data_c%0d", c),  64'(out_data),  64'(bp_exp[1]));
            end
            if (c == 9) check("bp_drain_ready", 64'(in_ready), 64'd1);
            if (out_fire) begin
                check($sformatf("bp_out%0d", bp_q), 64'(out_data), 64'(bp_exp[bp_q]));
                bp_q++;
            end
            if (in_fire) bp_p++;
            @(posedge clock);
            #1;
        end
        check("bp_all_accepted",  64'(bp_p), 64'd5);
        check("bp_all_delivered", 64'(bp_q), 64'd5);
        drive(1'b0, '0, '0, 2'b00);
        out_ready = 1'b1;
        step();
        check("bp_no_duplicate", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
